// File: rtl/mac_dot_ctrl.sv
// mac_dot_ctrl -- streaming signed 8x8 dot-product engine with handshake control.
//
// A job starts in IDLE when start is high. len gives the number of a/b operand
// pairs. The pairs are accepted in RUN through an in_valid/in_ready handshake.
// Each pair goes through a three-stage pipeline:
//   1. operand registers
//   2. a 16-bit signed product register
//   3. a 16-bit wrapping accumulator with a sticky signed-overflow flag
// After the final pair the FSM waits in DRAIN for the pipeline to empty. It then
// presents the result in DONE until res_ready is high.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      begin a new job (only looked at in IDLE)
//   len        number of operand pairs, captured with start
//   in_valid   operand pair a/b valid
//   in_ready   high only in RUN
//   a, b       signed 8-bit operands
//   res        accumulator value (valid in every state; final in DONE)
//   res_valid  high in DONE
//   res_ready  consumer accepts res
//   busy       high in every state except IDLE
//   ovf        sticky signed overflow of the current result
module mac_dot_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic [15:0]      res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [LEN_W-1:0]   cnt_reg;
  logic               s1v_reg;
  logic               s2v_reg;
  logic signed [7:0]  a_reg;
  logic signed [7:0]  b_reg;
  logic signed [15:0] pp_reg;
  logic signed [15:0] acc_reg;
  logic               ovf_reg;

  logic               beat;
  logic               final_beat;
  logic               job_start;
  logic signed [15:0] product;
  logic signed [15:0] sum;
  logic               ovf_hit;

  assign beat       = in_valid && in_ready;
  assign final_beat = beat && (cnt_reg == LEN_W'(1));
  assign job_start  = (state_reg == IDLE) && start;

  // Widening before the multiply keeps the full product.
  // This includes (-128)*(-128) = 16384.
  assign product = 16'(a_reg) * 16'(b_reg);
  assign sum     = acc_reg + pp_reg;

  // Signed overflow occurs when both addends have the same sign and the
  // wrapped sum has the other sign.
  assign ovf_hit = (acc_reg[15] == pp_reg[15]) && (sum[15] != acc_reg[15]);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (final_beat) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // The last product is in pp and stage 1 is empty.
        // This edge performs the final accumulate.
        if (s2v_reg && !s1v_reg) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    in_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state_reg)
      IDLE:    busy      = 1'b0;
      RUN:     in_ready  = 1'b1;
      DONE:    res_valid = 1'b1;
      default: ;
    endcase
  end

  assign res = acc_reg;
  assign ovf = ovf_reg;

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
      s1v_reg <= 1'b0;
      s2v_reg <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      pp_reg  <= '0;
      acc_reg <= '0;
      ovf_reg <= 1'b0;
    end else begin
      // Stage 1: capture the operands on a beat.
      // A bubble otherwise moves down the pipeline.
      if (beat) begin
        a_reg   <= a;
        b_reg   <= b;
        s1v_reg <= 1'b1;
        cnt_reg <= cnt_reg - LEN_W'(1);
      end else begin
        s1v_reg <= 1'b0;
      end

      // Stage 2: product
      s2v_reg <= s1v_reg;
      if (s1v_reg) begin
        pp_reg <= product;
      end

      // Stage 3: accumulate.
      // A job can only start from IDLE, and the pipeline is always empty there.
      // So the clear on start and the accumulate never collide.
      if (job_start) begin
        cnt_reg <= len;
        acc_reg <= '0;
        ovf_reg <= 1'b0;
      end else if (s2v_reg) begin
        acc_reg <= sum;
        if (ovf_hit) begin
          ovf_reg <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// Self-checking bench for mac_dot_ctrl.
//
// The expected results come from a reference dot product computed over the
// operand queues. Each result is pushed to a scoreboard when its job starts.
// It is popped and compared when the block presents res_valid.
module tb_mac_dot_ctrl;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic [15:0]      res;
  logic             res_valid;
  logic             res_ready;
  logic             busy;
  logic             ovf;

  typedef struct packed {
    logic [15:0] res;
    logic        ovf;
  } result_t;

  result_t    sb[$];
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         compared   = 0;
  int         mismatched = 0;
  int         job_no     = 0;

  always #5 clk = ~clk;

  mac_dot_ctrl #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .res       (res),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .ovf       (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    compared++;
    assert (obs === req) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // Reference: plain integer dot product.
  // Overflow is detected by range and the result is wrapped to 16 bits.
  function automatic result_t model();
    result_t     r;
    int          acc_i;
    int          p;
    int          s;
    logic [15:0] s16;
    acc_i = 0;
    r.ovf = 1'b0;
    for (int i = 0; i < qa.size(); i++) begin
      p = $signed(qa[i]) * $signed(qb[i]);
      s = acc_i + p;
      if (s > 32767 || s < -32768) r.ovf = 1'b1;
      s16   = s[15:0];
      acc_i = int'($signed(s16));
    end
    r.res = acc_i[15:0];
    return r;
  endfunction

  task automatic start_job(input int n, input bit expect_done);
    if (expect_done) sb.push_back(model());
    start = 1'b1;
    len   = n[LEN_W-1:0];
    tick();
    start = 1'b0;
    len   = 8'($urandom_range(0, 255));
  endtask

  task automatic feed(input bit gaps, input bit pulse_start);
    int guard;
    for (int i = 0; i < qa.size(); i++) begin
      guard    = 0;
      a        = qa[i];
      b        = qb[i];
      in_valid = 1'b1;
      while (!in_ready && guard < 20) begin
        tick();
        guard++;
      end
      chk("in_ready_wait", 32'(guard < 20), 1);
      tick();
      in_valid = 1'b0;
      if (gaps && i != qa.size() - 1) begin
        if (pulse_start && i == 0) begin
          start = 1'b1;
          len   = 8'd9;
        end
        tick();
        start = 1'b0;
      end
    end
  endtask

  task automatic pop_and_check(input int hold);
    result_t e;
    chk("sb_nonempty", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      job_no++;
      $display("job %0d: res=%0d ovf=%0b (expected res=%0d ovf=%0b)",
               job_no, $signed(res), ovf, $signed(e.res), e.ovf);
      chk("res", res, e.res);
      chk("ovf", ovf, e.ovf);
      for (int k = 0; k < hold; k++) begin
        tick();
        chk("hold_res_valid", res_valid, 1);
        chk("hold_res", res, e.res);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("res_valid_after_ack", res_valid, 0);
    chk("busy_after_ack", busy, 0);
  endtask

  // Called just after the edge that took the final beat.
  task automatic finish_job(input int hold);
    chk("in_ready_after_final", in_ready, 0);
    chk("res_valid_e0", res_valid, 0);
    tick();
    chk("res_valid_e1", res_valid, 0);
    chk("busy_drain", busy, 1);
    tick();
    chk("res_valid_e2", res_valid, 1);
    pop_and_check(hold);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    res_ready = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res", res, 0);

    // Three back-to-back pairs: 2 - 12 + 16 = 6
    qa = '{8'd1, 8'hFD, 8'd2};
    qb = '{8'd2, 8'd4, 8'd8};
    start_job(3, 1'b1);
    feed(1'b0, 1'b0);
    finish_job(0);

    // (-128)*(-128) on its own
    qa = '{8'h80};
    qb = '{8'h80};
    start_job(1, 1'b1);
    feed(1'b0, 1'b0);
    finish_job(0);

    // Two of them wrap to -32768 and set ovf
    qa = '{8'h80, 8'h80};
    qb = '{8'h80, 8'h80};
    start_job(2, 1'b1);
    feed(1'b0, 1'b0);
    finish_job(0);

    // Zero-length job goes straight to DONE and clears ovf
    qa = {};
    qb = {};
    start_job(0, 1'b1);
    chk("len0_busy", busy, 1);
    chk("len0_res_valid", res_valid, 1);
    pop_and_check(5);

    // Four pairs (5,5) with in_valid gaps and a start pulse during RUN
    qa = '{8'd5, 8'd5, 8'd5, 8'd5};
    qb = '{8'd5, 8'd5, 8'd5, 8'd5};
    start_job(4, 1'b1);
    feed(1'b1, 1'b1);
    finish_job(0);

    // Reset while in DRAIN, with start raised in the same cycle
    qa = '{8'd3, 8'd4};
    qb = '{8'd9, 8'd9};
    start_job(2, 1'b0);
    feed(1'b0, 1'b0);
    chk("drain_busy", busy, 1);
    reset = 1'b1;
    start = 1'b1;
    len   = 8'd1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("drain_rst_busy", busy, 0);
    chk("drain_rst_res", res, 0);
    chk("drain_rst_res_valid", res_valid, 0);
    chk("drain_rst_in_ready", in_ready, 0);
    chk("drain_rst_ovf", ovf, 0);

    // Fresh job after reset: 7 * -6 = -42
    qa = '{8'd7};
    qb = '{8'hFA};
    start_job(1, 1'b1);
    feed(1'b0, 1'b0);
    finish_job(0);

    chk("sb_empty_at_end", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
